// File: rtl/breathe_sequencer.sv
// -----------------------------------------------------------------------------
// breathe_sequencer
//
// Sequences the duty reference for one breathing-LED PWM channel. While
// enabled, duty ramps from `floor` up to `peak` one count per step, holds,
// ramps back down to `floor`, holds again and repeats. A step is produced
// every (step_div + 1) clocks by an internal prescaler. All limits are read
// live on every step, so they may be retuned while running.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable      run request, level-sensitive; low returns to IDLE next clock
//   step_div    clocks per duty step minus 1 (0 = step every clock)
//   hold_steps  extra steps spent in each hold state (0 = one step)
//   peak        maximum duty
//   floor       minimum duty
//   duty        registered duty reference to the PWM comparator
//   duty_upd    one-clock pulse in the cycle a new duty value first appears
//   phase       current state: IDLE=0 RISE=1 HOLD_HI=2 FALL=3 HOLD_LO=4
//   cycle_done  one-clock pulse when a full breath completes (HOLD_LO -> RISE)
// -----------------------------------------------------------------------------
module breathe_sequencer #(
    parameter int DUTY_W = 6,
    parameter int TICK_W = 10,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [TICK_W-1:0] step_div,
    input  logic [HOLD_W-1:0] hold_steps,
    input  logic [DUTY_W-1:0] peak,
    input  logic [DUTY_W-1:0] floor,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic [2:0]        phase,
    output logic              cycle_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_e;

    state_e            state_q;
    logic [DUTY_W-1:0] duty_q;
    logic [TICK_W-1:0] tick_q;
    logic [HOLD_W-1:0] hold_q;
    logic              upd_q;
    logic              done_q;
    logic              step;

    // Live compare, so a new step_div takes effect at the next comparison.
    assign step = (tick_q == step_div);

    // NOTE: every register, including the prescaler and hold counter, is in the
    // async reset branch and updated with non-blocking assignments so all of
    // them sample the pre-edge values of each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tick_q  <= '0;
            hold_q  <= '0;
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // Pulses default low so each event yields exactly one clock.
            upd_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tick_q <= '0;
                    hold_q <= '0;
                    duty_q <= '0;
                    if (enable) begin
                        state_q <= RISE;
                        duty_q  <= floor;
                        upd_q   <= 1'b1;   // pulses even when floor is 0
                    end
                end
                RISE, HOLD_HI, FALL, HOLD_LO: begin
                    if (!enable) begin
                        // Disable wins over a coincident step.
                        state_q <= IDLE;
                        duty_q  <= '0;
                        tick_q  <= '0;
                        hold_q  <= '0;
                        upd_q   <= (duty_q != '0);
                    end else begin
                        tick_q <= step ? '0 : tick_q + TICK_W'(1);
                        if (step) begin
                            case (state_q)
                                RISE: begin
                                    // >= so a peak lowered below duty exits without a decrement.
                                    if (duty_q >= peak) begin
                                        state_q <= HOLD_HI;
                                        hold_q  <= '0;
                                    end else begin
                                        duty_q <= duty_q + DUTY_W'(1);
                                        upd_q  <= 1'b1;
                                    end
                                end
                                HOLD_HI: begin
                                    if (hold_q == hold_steps) state_q <= FALL;
                                    else                      hold_q  <= hold_q + HOLD_W'(1);
                                end
                                FALL: begin
                                    if (duty_q <= floor) begin
                                        state_q <= HOLD_LO;
                                        hold_q  <= '0;
                                    end else begin
                                        duty_q <= duty_q - DUTY_W'(1);
                                        upd_q  <= 1'b1;
                                    end
                                end
                                HOLD_LO: begin
                                    // duty is deliberately not reloaded from floor here.
                                    if (hold_q == hold_steps) begin
                                        state_q <= RISE;
                                        done_q  <= 1'b1;
                                    end else begin
                                        hold_q <= hold_q + HOLD_W'(1);
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: begin
                    // Unreachable encodings fall back to a clean IDLE.
                    state_q <= IDLE;
                    duty_q  <= '0;
                    tick_q  <= '0;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign duty       = duty_q;
    assign duty_upd   = upd_q;
    assign phase      = state_q;
    assign cycle_done = done_q;

endmodule
